axis_frame_fifo: RTL and testbench

Store-and-forward AXI4-Stream frame FIFO placed directly downstream of `axis_shutdown`, between the gated stream and the DMA/consumer. It releases a frame on M_AXIS only after its `tlast` beat has been stored, so downstream never sees a partial frame from overflow or error. Frames that overflow or carry an error flag are discarded whole and counted. A `flush` input, driven from `axis_shutdown.shutdown_ack`, empties the buffer during shutdown.

---
 rtl/axis_frame_fifo_pkg.sv | 15 +
 rtl/sdp_ram.sv | 27 ++
 rtl/axis_frame_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_axis_frame_fifo.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI4-Stream frame FIFO.
package axis_frame_fifo_pkg;

    typedef enum logic [0:0] {
        ST_PASS = 1'b0,
        ST_DROP = 1'b1
    } wr_state_t;

    localparam int ERR_BIT = 0;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (BRAM style).
module sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/axis_frame_fifo.sv
// Store-and-forward frame FIFO: frames are released only once complete and error-free;
// overflowing or errored frames are discarded whole and counted.
//
// state   | meaning
// ST_PASS | storing beats of the current frame at wr_ptr
// ST_DROP | discarding the rest of a frame until its tlast
module axis_frame_fifo
    import axis_frame_fifo_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_AXIS_TUSER_WIDTH = 1,
    parameter int C_DEPTH            = 2048
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tlast,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [31:0]                     drop_count,
    output logic [$clog2(C_DEPTH):0]        frame_count
);

    localparam int PW = ptr_width(C_DEPTH);
    localparam int AW = PW - 1;
    localparam int KW = C_AXIS_TDATA_WIDTH / 8;
    localparam int WW = 1 + C_AXIS_TUSER_WIDTH + KW + C_AXIS_TDATA_WIDTH;
    localparam logic [PW-1:0] FULL_OCC = {1'b1, {AW{1'b0}}};

    wr_state_t     st_q, st_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
    logic [PW-1:0] frame_cnt_q, frame_cnt_d;
    logic [31:0]   drop_cnt_q, drop_cnt_d;
    logic          ram_vld_q, ram_vld_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic [WW-1:0] ob0_q, ob0_d, ob1_q, ob1_d, ram_rdata;
    logic          s_acc, full, ram_we, commit, rollback, drop;
    logic          pop, push, fetch, ob_dec;
    logic [2:0]    ob_lvl;

    assign s_axis_tready = rst_n & ~flush;
    assign s_acc         = s_axis_tvalid & s_axis_tready;
    // rd_ptr only moves on M-side handshakes, so prefetched beats still count as occupied
    assign full          = (wr_ptr_q - rd_ptr_q) == FULL_OCC;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q <= ST_PASS;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = (st_q == ST_DROP || wr_ptr_q != wr_commit_q) ? ST_DROP : ST_PASS;
        end else if (s_acc) begin
            case (st_q)
                ST_PASS: if (full && !s_axis_tlast) st_d = ST_DROP;
                ST_DROP: if (s_axis_tlast)          st_d = ST_PASS;
                default: st_d = ST_PASS;
            endcase
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        drop     = 1'b0;
        if (s_acc && st_q == ST_PASS) begin
            if (full) begin
                rollback = 1'b1;
                drop     = 1'b1;
            end else begin
                ram_we = 1'b1;
                if (s_axis_tlast) begin
                    if (s_axis_tuser[ERR_BIT]) begin
                        rollback = 1'b1;
                        drop     = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        if (flush) begin
            wr_ptr_d    = '0;
            wr_commit_d = '0;
        end else if (rollback) begin
            wr_ptr_d = wr_commit_q;
        end else if (ram_we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (commit) wr_commit_d = wr_ptr_q + PW'(1);
        end
        drop_cnt_d = (drop && drop_cnt_q != 32'hFFFF_FFFF) ? drop_cnt_q + 32'd1 : drop_cnt_q;
    end

    assign m_axis_tvalid = (ob_cnt_q != 2'd0);
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign push          = ram_vld_q;
    assign ob_dec        = pop & ob0_q[WW-1];
    // Fetch only when the beat landing next cycle is guaranteed a slot in the skid buffer
    assign ob_lvl        = {1'b0, ob_cnt_q} + {2'b0, ram_vld_q} - {2'b0, pop};
    assign fetch         = !flush && (fetch_ptr_q != wr_commit_q) && (ob_lvl < 3'd2);

    always_comb begin
        rd_ptr_d    = flush ? '0 : (pop ? rd_ptr_q + PW'(1) : rd_ptr_q);
        fetch_ptr_d = flush ? '0 : (fetch ? fetch_ptr_q + PW'(1) : fetch_ptr_q);
        ram_vld_d   = fetch;
        ob0_d       = ob0_q;
        ob1_d       = ob1_q;
        ob_cnt_d    = ob_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (flush) begin
            ob_cnt_d    = 2'd0;
            frame_cnt_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (ob_cnt_q == 2'd0) ob0_d = ram_rdata;
                    else                  ob1_d = ram_rdata;
                    ob_cnt_d = ob_cnt_q + 2'd1;
                end
                2'b01: begin
                    ob0_d    = ob1_q;
                    ob_cnt_d = ob_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (ob_cnt_q == 2'd1) begin
                        ob0_d = ram_rdata;
                    end else begin
                        ob0_d = ob1_q;
                        ob1_d = ram_rdata;
                    end
                end
                default: ;
            endcase
            case ({commit, ob_dec})
                2'b10:   frame_cnt_d = frame_cnt_q + PW'(1);
                2'b01:   frame_cnt_d = frame_cnt_q - PW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            fetch_ptr_q <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ram_vld_q   <= 1'b0;
            ob_cnt_q    <= 2'd0;
            ob0_q       <= '0;
            ob1_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            fetch_ptr_q <= fetch_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ram_vld_q   <= ram_vld_d;
            ob_cnt_q    <= ob_cnt_d;
            ob0_q       <= ob0_d;
            ob1_q       <= ob1_d;
        end
    end

    sdp_ram #(
        .WIDTH (WW),
        .DEPTH (C_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
        .re_i    (fetch),
        .raddr_i (fetch_ptr_q[AW-1:0]),
        .rdata_o (ram_rdata)
    );

    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = ob0_q;
    assign drop_count  = drop_cnt_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Bench for axis_frame_fifo: a deep instance checked against a frame-level scoreboard
// and a 16-deep instance for overflow behaviour; both share the stimulus.
module tb_axis_frame_fifo;

    localparam int DW = 32;
    localparam int KW = 4;
    localparam int UW = 1;
    localparam int WW = 1 + UW + KW + DW;
    typedef logic [WW-1:0] word_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic [UW-1:0] s_tuser = '0;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;

    logic          b_s_tready, b_m_tlast, b_m_tvalid;
    logic [DW-1:0] b_m_tdata;
    logic [KW-1:0] b_m_tkeep;
    logic [UW-1:0] b_m_tuser;
    logic [31:0]   b_drop;
    logic [11:0]   b_frame;

    logic          s_s_tready, s_m_tlast, s_m_tvalid;
    logic [DW-1:0] s_m_tdata;
    logic [KW-1:0] s_m_tkeep;
    logic [UW-1:0] s_m_tuser;
    logic [31:0]   s_drop;
    logic [4:0]    s_frame;

    always #5 clk = ~clk;

    axis_frame_fifo #(.C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_DEPTH(2048)) dut_big (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(b_s_tready),
        .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep), .m_axis_tuser(b_m_tuser),
        .m_axis_tlast(b_m_tlast), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(m_tready),
        .drop_count(b_drop), .frame_count(b_frame)
    );

    axis_frame_fifo #(.C_AXIS_TDATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW), .C_DEPTH(16)) dut_small (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_s_tready),
        .m_axis_tdata(s_m_tdata), .m_axis_tkeep(s_m_tkeep), .m_axis_tuser(s_m_tuser),
        .m_axis_tlast(s_m_tlast), .m_axis_tvalid(s_m_tvalid), .m_axis_tready(m_tready),
        .drop_count(s_drop), .frame_count(s_frame)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t exp_q[$], cur_q[$], got_b[$], got_s[$], sent_q[$];
    int    got_b_cyc[$], last_cyc[$];
    bit    skip, prev_stall;
    word_t prev_word;
    int    hold_viol, rdy_low;

    // Monitor and frame-level reference model: a frame is expected on the output iff its
    // tlast arrives with no error flag; flush loses everything not yet delivered and
    // the remainder of any frame in progress.
    always @(negedge clk) begin
        word_t wb, ws, wi;
        wb = {b_m_tlast, b_m_tuser, b_m_tkeep, b_m_tdata};
        ws = {s_m_tlast, s_m_tuser, s_m_tkeep, s_m_tdata};
        wi = {s_tlast, s_tuser, s_tkeep, s_tdata};
        if (!rst_n) begin
            exp_q.delete(); cur_q.delete(); got_b.delete(); got_s.delete();
            got_b_cyc.delete(); last_cyc.delete();
            skip = 1'b0; prev_stall = 1'b0; hold_viol = 0; rdy_low = 0;
        end else begin
            if (prev_stall && (b_m_tvalid !== 1'b1 || wb !== prev_word)) hold_viol++;
            prev_stall = !flush && b_m_tvalid && !m_tready;
            prev_word  = wb;
            if (b_m_tvalid && m_tready) begin
                got_b.push_back(wb);
                got_b_cyc.push_back(cyc);
            end
            if (s_m_tvalid && m_tready) got_s.push_back(ws);
            if (s_tvalid && !s_s_tready && !flush) rdy_low++;
            if (flush) begin
                while (exp_q.size() > got_b.size()) void'(exp_q.pop_back());
                if (cur_q.size() > 0) skip = 1'b1;
                cur_q.delete();
            end else if (s_tvalid && b_s_tready) begin
                if (s_tlast) last_cyc.push_back(cyc);
                if (skip) begin
                    if (s_tlast) skip = 1'b0;
                end else begin
                    cur_q.push_back(wi);
                    if (s_tlast) begin
                        if (!s_tuser[0]) foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        cur_q.delete();
                    end
                end
            end
        end
    end

    task automatic do_reset(input logic rdy);
        rst_n = 1'b0; flush = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = rdy;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sent_q.delete();
    endtask

    task automatic drive_beat(input logic last, input logic err);
        s_tvalid = 1'b1;
        s_tdata  = $urandom;
        s_tkeep  = KW'($urandom);
        s_tuser  = last ? err : UW'($urandom_range(0, 1));
        s_tlast  = last;
        sent_q.push_back({s_tlast, s_tuser, s_tkeep, s_tdata});
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic err);
        for (int i = 0; i < len; i++) drive_beat(i == len - 1, err);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (b_s_tready !== 1'b0) begin failures++; $display("FAIL reset_s_tready: got %b want 0", b_s_tready); end
        checks++; if (b_m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid: got %b want 0", b_m_tvalid); end
        checks++; if ({b_m_tlast, b_m_tuser, b_m_tkeep, b_m_tdata} !== '0) begin failures++;
            $display("FAIL reset_m_payload: got %h want 0", {b_m_tlast, b_m_tuser, b_m_tkeep, b_m_tdata}); end
        checks++; if (b_drop !== 32'd0) begin failures++; $display("FAIL reset_drop_count: got %0d want 0", b_drop); end
        checks++; if (b_frame !== 12'd0) begin failures++; $display("FAIL reset_frame_count: got %0d want 0", b_frame); end
        rst_n = 1'b1;
        #1;
        checks++; if (b_s_tready !== 1'b1) begin failures++; $display("FAIL post_reset_s_tready: got %b want 1", b_s_tready); end
    endtask

    task automatic test_back_to_back();
        int mism, lat, t;
        do_reset(1'b1);
        send_frame(4, 1'b0);
        send_frame(4, 1'b0);
        send_frame(4, 1'b0);
        t = 0;
        while (got_b.size() < 12 && t < 50) begin idle(1); t++; end
        idle(2);
        mism = 0;
        foreach (sent_q[i]) if (i >= got_b.size() || got_b[i] !== sent_q[i]) mism++;
        lat = (got_b_cyc.size() > 0 && last_cyc.size() > 0) ? got_b_cyc[0] - last_cyc[0] : -1;
        checks++; if (got_b.size() != 12) begin failures++; $display("FAIL b2b_beat_count: got %0d want 12", got_b.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL b2b_order: %0d beats differ, want 0", mism); end
        checks++; if (lat != 3) begin failures++; $display("FAIL b2b_latency: got %0d cycles want 3", lat); end
        checks++; if (b_frame !== 12'd0) begin failures++; $display("FAIL b2b_frame_count: got %0d want 0", b_frame); end
    endtask

    task automatic test_error_frame();
        int mism, t;
        do_reset(1'b1);
        send_frame(5, 1'b1);
        sent_q.delete();
        send_frame(3, 1'b0);
        t = 0;
        while (got_b.size() < 3 && t < 50) begin idle(1); t++; end
        idle(5);
        mism = 0;
        foreach (sent_q[i]) if (i >= got_b.size() || got_b[i] !== sent_q[i]) mism++;
        checks++; if (got_b.size() != 3) begin failures++; $display("FAIL err_beat_count: got %0d want 3", got_b.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL err_good_frame: %0d beats differ, want 0", mism); end
        checks++; if (got_b != exp_q) begin failures++; $display("FAIL err_model: got %0d beats, model %0d", got_b.size(), exp_q.size()); end
        checks++; if (b_drop !== 32'd1) begin failures++; $display("FAIL err_drop_count: got %0d want 1", b_drop); end
    endtask

    task automatic test_overflow();
        word_t frame_a[$];
        int mism;
        do_reset(1'b0);
        send_frame(10, 1'b0);
        frame_a = sent_q;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                checks++; if (s_drop !== 32'd0) begin failures++; $display("FAIL ovf_drop_before_full: got %0d want 0", s_drop); end
            end
            drive_beat(i == 9, 1'b0);
            if (i == 6) begin
                checks++; if (s_drop !== 32'd1) begin failures++; $display("FAIL ovf_drop_at_7th: got %0d want 1", s_drop); end
            end
        end
        idle(2);
        checks++; if (s_frame !== 5'd1) begin failures++; $display("FAIL ovf_frame_count: got %0d want 1", s_frame); end
        checks++; if (rdy_low != 0) begin failures++; $display("FAIL ovf_s_tready_low: %0d cycles low, want 0", rdy_low); end
        m_tready = 1'b1;
        idle(40);
        mism = 0;
        foreach (frame_a[i]) if (i >= got_s.size() || got_s[i] !== frame_a[i]) mism++;
        checks++; if (got_s.size() != 10) begin failures++; $display("FAIL ovf_beat_count: got %0d want 10", got_s.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL ovf_first_frame: %0d beats differ, want 0", mism); end
        checks++; if (s_frame !== 5'd0) begin failures++; $display("FAIL ovf_frame_drain: got %0d want 0", s_frame); end
    endtask

    task automatic test_long_frame();
        do_reset(1'b1);
        send_frame(20, 1'b0);
        idle(20);
        checks++; if (s_drop !== 32'd1) begin failures++; $display("FAIL long_drop_count: got %0d want 1", s_drop); end
        checks++; if (s_frame !== 5'd0) begin failures++; $display("FAIL long_frame_count: got %0d want 0", s_frame); end
        checks++; if (got_s.size() != 0) begin failures++; $display("FAIL long_output: got %0d beats want 0", got_s.size()); end
    endtask

    task automatic test_flush();
        int mism, t;
        do_reset(1'b0);
        send_frame(4, 1'b0);
        send_frame(5, 1'b0);
        for (int i = 0; i < 3; i++) drive_beat(1'b0, 1'b0);
        idle(4);
        checks++; if (b_m_tvalid !== 1'b1) begin failures++; $display("FAIL flush_pre_tvalid: got %b want 1", b_m_tvalid); end
        checks++; if (b_frame !== 12'd2) begin failures++; $display("FAIL flush_pre_frame_count: got %0d want 2", b_frame); end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (b_m_tvalid !== 1'b0) begin failures++; $display("FAIL flush_tvalid: got %b want 0", b_m_tvalid); end
        checks++; if (b_frame !== 12'd0) begin failures++; $display("FAIL flush_frame_count: got %0d want 0", b_frame); end
        for (int i = 0; i < 3; i++) drive_beat(i == 2, 1'b0);
        sent_q.delete();
        send_frame(5, 1'b0);
        m_tready = 1'b1;
        t = 0;
        while (got_b.size() < 5 && t < 50) begin idle(1); t++; end
        idle(10);
        mism = 0;
        foreach (sent_q[i]) if (i >= got_b.size() || got_b[i] !== sent_q[i]) mism++;
        checks++; if (got_b.size() != 5) begin failures++; $display("FAIL flush_beat_count: got %0d want 5", got_b.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL flush_next_frame: %0d beats differ, want 0", mism); end
        checks++; if (got_b != exp_q) begin failures++; $display("FAIL flush_model: got %0d beats, model %0d", got_b.size(), exp_q.size()); end
    endtask

    task automatic test_random();
        int mism, t, len;
        logic v;
        do_reset(1'b0);
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 64);
            for (int b = 0; b < len; b++) begin
                v = 1'b0;
                while (!v) begin
                    v = 1'($urandom_range(0, 1));
                    m_tready = 1'($urandom_range(0, 1));
                    s_tvalid = v;
                    if (v) begin
                        s_tdata = $urandom;
                        s_tkeep = KW'($urandom);
                        s_tlast = (b == len - 1);
                        s_tuser = s_tlast ? 1'b0 : UW'($urandom_range(0, 1));
                    end
                    @(posedge clk);
                    #1;
                end
                sent_q.push_back({s_tlast, s_tuser, s_tkeep, s_tdata});
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        t = 0;
        while (got_b.size() < sent_q.size() && t < 20000) begin
            m_tready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            t++;
        end
        m_tready = 1'b1;
        idle(5);
        mism = 0;
        foreach (sent_q[i]) if (i >= got_b.size() || got_b[i] !== sent_q[i]) mism++;
        checks++; if (got_b.size() != sent_q.size()) begin failures++;
            $display("FAIL rand_beat_count: got %0d want %0d", got_b.size(), sent_q.size()); end
        checks++; if (mism != 0) begin failures++; $display("FAIL rand_stream: %0d beats differ, want 0", mism); end
        checks++; if (got_b != exp_q) begin failures++; $display("FAIL rand_model: got %0d beats, model %0d", got_b.size(), exp_q.size()); end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL rand_hold_stable: %0d violations, want 0", hold_viol); end
        checks++; if (b_drop !== 32'd0) begin failures++; $display("FAIL rand_drop_count: got %0d want 0", b_drop); end
        checks++; if (b_frame !== 12'd0) begin failures++; $display("FAIL rand_frame_count: got %0d want 0", b_frame); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_error_frame();
        test_overflow();
        test_long_frame();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
